// File: rtl/waveform_recorder_pkg.sv
// waveform_recorder_pkg
//   Shared definitions for the waveform recorder: CSR word addresses,
//   CTRL/STATUS bit positions, the packed stereo word layout and the
//   saturating magnitude helper used by the optional peak detector.
package waveform_recorder_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_PEAK   = 2'd3;

    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT  = 1;

    localparam int unsigned STAT_EMPTY_BIT    = 16;
    localparam int unsigned STAT_FULL_BIT     = 17;
    localparam int unsigned STAT_OVERFLOW_BIT = 18;

    // Left sample occupies the upper half of the 32-bit word.
    typedef struct packed {
        logic signed [15:0] left;
        logic signed [15:0] right;
    } stereo_word_t;

    // |x| for a 16-bit two's-complement sample; -32768 saturates to 32767.
    function automatic logic [15:0] abs_sat(input logic signed [15:0] x);
        logic [15:0] r;
        if (x == 16'sh8000)
            r = 16'h7FFF;
        else if (x < 0)
            r = 16'(-x);
        else
            r = 16'(x);
        return r;
    endfunction

endpackage

// File: rtl/waveform_recorder_if.sv
// waveform_recorder_if
//   Groups the Avalon-MM CSR slave bus and the left/right audio-in
//   Avalon-ST streams of the waveform recorder.
//   master : CPU bridge + audio core side (drives address/read/write/
//            writedata, x_audio_data/x_audio_valid)
//   slave  : recorder side (drives readdata, x_audio_ready)
interface waveform_recorder_if;

    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    logic [15:0] l_audio_data;
    logic        l_audio_valid;
    logic        l_audio_ready;
    logic [15:0] r_audio_data;
    logic        r_audio_valid;
    logic        r_audio_ready;

    modport master (
        output address, read, write, writedata,
        output l_audio_data, l_audio_valid, r_audio_data, r_audio_valid,
        input  readdata, l_audio_ready, r_audio_ready
    );

    modport slave (
        input  address, read, write, writedata,
        input  l_audio_data, l_audio_valid, r_audio_data, r_audio_valid,
        output readdata, l_audio_ready, r_audio_ready
    );

endinterface

// File: rtl/waveform_recorder_sample_fifo.sv
// sample_fifo
//   Single-clock synchronous FIFO with push, pop and clear. rdata shows
//   the head entry combinationally, so on a simultaneous push/pop the
//   popped word is the old head. Clear has priority over push and pop.
//   Ports: clk, rst_n (async, active low), clear, push, pop, wdata,
//          rdata (head), count ($clog2(DEPTH)+1 bits), full, empty.
//   DEPTH must be a power of two (pointers wrap naturally).
module sample_fifo #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/waveform_recorder.sv
// waveform_recorder
//   Captures left/right audio-in streams, pairs them into {L,R} 32-bit
//   words and buffers them in a FIFO readable over an Avalon-MM slave.
//   Ports: clock, reset_n (async, active low), bus (waveform_recorder_if
//          slave: CSR bus + audio-in streams).
//   CSRs: 0 CTRL (bit0 enable, bit1 clear), 1 STATUS (count/empty/full/
//         overflow), 2 DATA (pop head), 3 PEAK.
//   Optional: define WAVEFORM_RECORDER_PEAK_DETECT_EN to build the peak
//   magnitude detector; otherwise PEAK reads 0.
module waveform_recorder
    import waveform_recorder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 256,
    parameter int unsigned SAMPLE_WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    waveform_recorder_if.slave bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic                    enable;
    logic                    overflow;
    logic                    l_held;
    logic                    r_held;
    logic [SAMPLE_WIDTH-1:0] l_hold;
    logic [SAMPLE_WIDTH-1:0] r_hold;
    logic [CW-1:0]           count;
    logic                    full;
    logic                    empty;
    stereo_word_t            head;
    stereo_word_t            push_word;
    logic                    ctrl_wr;
    logic                    clear;
    logic                    pair_ready;
    logic                    push;
    logic                    pop;
    logic                    push_ok;
    logic [31:0]             rd_mux;
    logic [31:0]             peak_word;
    logic                    unused_wdata;

    assign unused_wdata = ^bus.writedata[31:2];

    assign ctrl_wr    = bus.write && (bus.address == ADDR_CTRL);
    assign clear      = ctrl_wr && bus.writedata[CTRL_CLEAR_BIT];
    assign pair_ready = l_held && r_held;
    assign push       = pair_ready && !clear;
    assign pop        = bus.read && (bus.address == ADDR_DATA) && !empty && !clear;
    // A full FIFO still accepts the pair when a pop frees a slot this cycle.
    assign push_ok    = push && (!full || pop);
    assign push_word  = {l_hold, r_hold};

    assign bus.l_audio_ready = enable && !l_held;
    assign bus.r_audio_ready = enable && !r_held;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ctrl_wr)
                enable <= bus.writedata[CTRL_ENABLE_BIT];
            if (clear)
                overflow <= 1'b0;
            else if (push && !push_ok)
                overflow <= 1'b1;
        end
    end

    // A completed pair is consumed (pushed or dropped) on the cycle after
    // its second sample arrives; clear or disable discards any partial pair.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            l_held <= 1'b0;
            r_held <= 1'b0;
            l_hold <= '0;
            r_hold <= '0;
        end else if (clear || !enable || pair_ready) begin
            l_held <= 1'b0;
            r_held <= 1'b0;
        end else begin
            if (bus.l_audio_valid && bus.l_audio_ready) begin
                l_held <= 1'b1;
                l_hold <= bus.l_audio_data;
            end
            if (bus.r_audio_valid && bus.r_audio_ready) begin
                r_held <= 1'b1;
                r_hold <= bus.r_audio_data;
            end
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clock),
        .rst_n (reset_n),
        .clear (clear),
        .push  (push_ok),
        .pop   (pop),
        .wdata (push_word),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef WAVEFORM_RECORDER_PEAK_DETECT_EN
    logic [15:0] peak;
    logic [15:0] pair_peak;
    logic [15:0] peak_base;
    logic        peak_rd;
    logic [15:0] mag_l;
    logic [15:0] mag_r;

    assign peak_rd   = bus.read && (bus.address == ADDR_PEAK);
    assign mag_l     = abs_sat(push_word.left);
    assign mag_r     = abs_sat(push_word.right);
    assign pair_peak = (mag_l > mag_r) ? mag_l : mag_r;
    // A read clears the peak, but a push landing the same cycle still counts.
    assign peak_base = peak_rd ? 16'h0000 : peak;
    assign peak_word = {16'h0000, peak};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            peak <= '0;
        else if (clear)
            peak <= '0;
        else if (push_ok)
            peak <= (pair_peak > peak_base) ? pair_peak : peak_base;
        else if (peak_rd)
            peak <= '0;
    end
`else
    assign peak_word = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_CTRL:   rd_mux[CTRL_ENABLE_BIT] = enable;
            ADDR_STATUS: begin
                rd_mux[15:0]              = 16'(count);
                rd_mux[STAT_EMPTY_BIT]    = empty;
                rd_mux[STAT_FULL_BIT]     = full;
                rd_mux[STAT_OVERFLOW_BIT] = overflow;
            end
            ADDR_DATA: begin
                if (!empty)
                    rd_mux = head;
            end
            default:     rd_mux = peak_word;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            bus.readdata <= '0;
        else if (bus.read)
            bus.readdata <= rd_mux;
        else
            bus.readdata <= '0;
    end

endmodule

// File: doc/waveform_recorder.md
Name: waveform_recorder

Overview:
- Capture-side counterpart of waveform_player. Sinks the left/right audio-in Avalon-ST streams from the audio core.
- Pairs each left/right sample into one 32-bit word and buffers it in a FIFO.
- Exposes the FIFO and control/status registers to the CPU through an Avalon-MM slave.
- Sits between the audio core ADC side and the HPS bridge, in the `clock` domain; the audio core streams are synchronous to `clock`.

Parameters:
- FIFO_DEPTH, 256, number of stereo words buffered; power of two, 4..4096.
- SAMPLE_WIDTH, 16, bits per channel sample; fixed at 16 for the 32-bit word packing.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon-MM word address.
- read  in  1  Avalon-MM read strobe.
- write  in  1  Avalon-MM write strobe.
- writedata  in  32  Avalon-MM write data.
- readdata  out  32  Avalon-MM read data; read latency 1.
- l_audio_data  in  16  left ADC sample.
- l_audio_valid  in  1  left sample valid.
- l_audio_ready  out  1  left sample accepted.
- r_audio_data  in  16  right ADC sample.
- r_audio_valid  in  1  right sample valid.
- r_audio_ready  out  1  right sample accepted.

Behaviour:
- Reset values: all outputs 0. Reset also clears enable, holding regs, FIFO, count, overflow and peak.
- Register map:
  - 0 CTRL (R/W): bit0 enable; bit1 clear, write-1, self-clearing, reads 0.
  - 1 STATUS (R): [15:0] count; bit16 empty; bit17 full; bit18 overflow (sticky).
  - 2 DATA (R): returns head word {L[31:16], R[15:0]} and pops it.
  - 3 PEAK (R): see optional feature.
- Reads: readdata is registered and valid the cycle after read. Writes to addresses 1-3 are ignored.
- DATA read when empty: returns 0x00000000, no pop, count unchanged.
- Channel capture:
  - Each channel has a holding register plus a held flag.
  - x_audio_ready = enable && !x_held.
  - Transfer occurs when valid && ready; sets held and latches the data.
  - L and R are captured independently, in any order or the same cycle.
- Push:
  - When l_held && r_held, push {L,R} next cycle and clear both held flags.
  - Held-to-ready turnaround is 1 cycle, so the audio core is never stalled more than 2 cycles.
- Full FIFO at push: pair is dropped, held flags are still cleared, overflow set. The audio stream is never back-pressured beyond the turnaround.
- Simultaneous push and pop: both take effect; count unchanged; popped word is the old head. On an empty FIFO the push completes and the read returns 0.
- Clear: empties FIFO, zeroes count and overflow, discards any half-captured pair. Clear has priority over a push or pop in the same cycle.
- Enable deasserted mid-pair: ready drops the next cycle; any half-held sample is discarded. FIFO contents are kept and remain readable.
- Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits, zero-extended into [15:0].

Optional Feature:
- Macro WAVEFORM_RECORDER_PEAK_DETECT_EN.
- Defined:
  - PEAK[15:0] holds the maximum absolute value (two's-complement, |-32768| saturates to 32767) across both channels of all pushed pairs since the last clear/reset.
  - PEAK updates the cycle after the push.
  - A PEAK read also clears it, unless a push lands the same cycle, in which case the new value wins.
- Undefined: PEAK reads 0 and no peak logic is synthesised.

Decomposition:
- waveform_recorder_pkg:
  - Register address constants (CTRL, STATUS, DATA, PEAK).
  - CTRL/STATUS bit indices.
  - Stereo word typedef (struct of two logic signed [15:0]).
- Sub-module sample_fifo: synchronous single-clock FIFO with push, pop, clear, count, full and empty; parameterised by DEPTH and WIDTH; read-first data on simultaneous push/pop.

Test Plan:
- Reset, write CTRL=0x1, feed L=0x1234 then R=0xABCD 3 cycles apart -> STATUS count=1; DATA read returns 0x1234ABCD; STATUS then empty=1.
- Enable, push FIFO_DEPTH+2 pairs without reading -> full=1, overflow=1, count=FIFO_DEPTH; first DATA read returns the first pair; write CTRL=0x3 -> count=0, overflow=0, enable stays 1.
- Hold FIFO at count=5, issue a DATA read in the same cycle a pair completes -> count stays 5; returned word is the old head.
- Read DATA with FIFO empty -> readdata=0, count stays 0; no underflow visible in a later STATUS read.
- Deliver L only, then write CTRL=0x0 -> l_audio_ready=0 next cycle; re-enable and deliver R=0x0001, L=0x0002 -> single word 0x00020001 pushed, stale L discarded.
- With PEAK_DETECT_EN: push pairs (0x0100, 0xFF00), then (0x8000, 0x0000) -> PEAK reads 0x7FFF, and a second read returns 0; without the macro, PEAK always reads 0.
